// File: rtl/grf_wb_queue_pkg.sv
// Shared CPU definitions used by the write-back queue: register address width,
// data width, the hard-wired zero register and the queue entry layout.
package grf_wb_queue_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_queue_fwd_match.sv
// One forwarding lookup port: scans the queued entries from newest to oldest
// and returns the data of the first entry whose address matches the lookup.
module wb_fwd_match
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3,
  parameter int PW    = 2
) (
  input  logic [DEPTH-1:0][REG_AW-1:0] i_addrs,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_datas,
  input  logic [PW-1:0]                i_wptr,
  input  logic [CW-1:0]                i_count,
  input  logic [REG_AW-1:0]            i_lookup,
  output logic                         o_hit,
  output logic [DATA_W-1:0]            o_data
);

  logic              w_hit;
  logic [DATA_W-1:0] w_data;

  // Offset i walks back from the entry just below the write pointer; the
  // first valid match found is the newest one.
  always_comb begin
    w_hit  = 1'b0;
    w_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_hit && (CW'(i) < i_count) && (i_lookup != ZERO_REG) &&
          (i_addrs[i_wptr - PW'(i + 1)] == i_lookup)) begin
        w_hit  = 1'b1;
        w_data = i_datas[i_wptr - PW'(i + 1)];
      end else begin
        w_hit  = w_hit;
        w_data = w_data;
      end
    end
  end

  assign o_hit  = w_hit;
  assign o_data = w_data;

endmodule

// File: rtl/grf_wb_queue.sv
// Register-file write-back queue: buffers write-backs while the GRF write port
// is held, with forwarding of pending values. Define WB_TRACE_EN for a write trace.
module grf_wb_queue
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              grf_hold,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc,
  input  logic [REG_AW-1:0] fwd_a1,
  input  logic [REG_AW-1:0] fwd_a2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_d1,
  output logic [DATA_W-1:0] fwd_d2,
  output logic [CW-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t                   r_mem [DEPTH];
  logic [PW-1:0]               r_wptr;
  logic [PW-1:0]               r_rptr;
  logic [CW-1:0]               r_count;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  wb_entry_t                   w_head;
  logic [DEPTH-1:0][REG_AW-1:0] w_addrs;
  logic [DEPTH-1:0][DATA_W-1:0] w_datas;

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready = (r_count != CW'(DEPTH));
  assign w_empty  = (r_count == CW'(0));
  assign w_push   = in_valid && in_ready && (in_addr != ZERO_REG);
  assign w_pop    = !w_empty && !grf_hold;
  assign w_head   = r_mem[r_rptr];
  assign grf_we   = w_pop;
  assign count    = r_count;

  // Head entry presented to the register file, forced to zero when empty.
  always_comb begin
    if (w_empty) begin
      grf_a3 = '0;
      grf_wd = '0;
      grf_pc = '0;
    end else begin
      grf_a3 = w_head.addr;
      grf_wd = w_head.data;
      grf_pc = w_head.pc;
    end
  end

  // Entry storage: not reset, since validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{addr: in_addr, data: in_data, pc: in_pc};
    end
  end

  // Pointer and occupancy state; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Flatten the storage for the forwarding scanners.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_addrs[i] = r_mem[i].addr;
      w_datas[i] = r_mem[i].data;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .CW(CW), .PW(PW)) u_fwd1 (
    .i_addrs (w_addrs),
    .i_datas (w_datas),
    .i_wptr  (r_wptr),
    .i_count (r_count),
    .i_lookup(fwd_a1),
    .o_hit   (fwd_hit1),
    .o_data  (fwd_d1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .CW(CW), .PW(PW)) u_fwd2 (
    .i_addrs (w_addrs),
    .i_datas (w_datas),
    .i_wptr  (r_wptr),
    .i_count (r_count),
    .i_lookup(fwd_a2),
    .o_hit   (fwd_hit2),
    .o_data  (fwd_d2)
  );

`ifdef WB_TRACE_EN
  // Simulation trace of every register-file write.
  always_ff @(posedge clk) begin
    if (!reset && grf_we) begin
      $display("@%08h: $%02d <= %08h", grf_pc, grf_a3, grf_wd);
    end
  end
`else
`endif

endmodule

// File: doc/grf_wb_queue.md
GRF_WB_QUEUE -- requirements
Module: grf_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write-back entries (power of two, 2..16).
REQ-002 SHALL have parameter CW, default 3, occupancy counter width, equal to log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  write-back request present.
REQ-006 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-007 SHALL have port in_addr  input  5  destination register number.
REQ-008 SHALL have port in_data  input  32  value to write.
REQ-009 SHALL have port in_pc  input  32  PC of the producing instruction.
REQ-010 SHALL have port grf_hold  input  1  register file write port unavailable this cycle.
REQ-011 SHALL have port grf_we  output  1  register file write enable.
REQ-012 SHALL have port grf_a3  output  5  register file write address.
REQ-013 SHALL have port grf_wd  output  32  register file write data.
REQ-014 SHALL have port grf_pc  output  32  PC accompanying the write.
REQ-015 SHALL have ports fwd_a1 and fwd_a2  input  5 each  forwarding lookup addresses.
REQ-016 SHALL have ports fwd_hit1 and fwd_hit2  output  1 each  pending write matches the lookup address.
REQ-017 SHALL have ports fwd_d1 and fwd_d2  output  32 each  forwarded data.
REQ-018 SHALL have port count  output  CW  current occupancy.

Function
REQ-019 SHALL store requests in a circular FIFO of DEPTH entries, each holding {addr, data, pc}.
REQ-020 SHALL drive in_ready = (count != DEPTH), from registered state only.
REQ-021 SHALL accept a request on a rising edge where in_valid && in_ready.
REQ-022 SHALL discard accepted requests with in_addr == 0: not enqueued, count unchanged, never written.
REQ-023 SHALL drive grf_we = (count != 0) && !grf_hold; grf_a3, grf_wd and grf_pc SHALL come combinationally from the head entry.
REQ-024 SHALL pop the head on every rising edge where grf_we == 1.
REQ-025 SHALL drive grf_a3, grf_wd and grf_pc to 0 when empty.
REQ-026 SHALL preserve acceptance order exactly in the drained order; latency from acceptance into an empty queue to grf_we SHALL be one cycle.
REQ-027 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-028 SHALL reject pushes when full, holding in_ready low, even if a pop occurs in the same cycle.
REQ-029 SHALL wrap the read and write pointers modulo DEPTH.
REQ-030 SHALL set fwd_hitN = 1 when any valid entry has addr == fwd_aN and fwd_aN != 0; fwd_dN SHALL be the data of the newest such entry, otherwise 0.
REQ-031 SHALL exclude the same-cycle incoming request from forwarding, which covers queued entries only.
REQ-032 SHALL include the head entry in forwarding, even during the cycle it is popped.

Reset
REQ-033 SHALL, on reset, clear both pointers and count immediately and asynchronously; grf_we and both fwd_hit outputs SHALL be 0, and in_ready SHALL be 1.
REQ-034 SHALL drop all pending entries when reset is asserted mid-operation; entry storage need not be cleared.

Configuration
REQ-035 SHALL, with WB_TRACE_EN defined, print "@<pc hex8>: $<addr dec2> <= <data hex8>" in simulation on each edge where grf_we == 1.
REQ-036 SHALL, without WB_TRACE_EN, produce no display output; logic SHALL be identical.

Structure
REQ-037 SHALL take the register address width (5), data width (32) and zero-register constant from the shared cpu package.
REQ-038 SHALL implement forwarding as sub-module wb_fwd_match (one lookup port, instantiated twice), scanning from newest to oldest entry.

Verification
REQ-039 SHALL test: push (addr 5, data 0x1234, pc 0x3000) into an empty queue -> next cycle grf_we = 1, grf_a3 = 5, grf_wd = 0x1234; count returns to 0.
REQ-040 SHALL test: grf_hold = 1 while pushing 4 entries -> count = 4, in_ready = 0, a 5th push is ignored; release hold -> 4 writes emitted in order.
REQ-041 SHALL test: push addr 0, data 0xFFFF -> count stays 0, grf_we never asserts.
REQ-042 SHALL test: with hold active, queue (7, 0xA) then (7, 0xB), fwd_a1 = 7 -> fwd_hit1 = 1, fwd_d1 = 0xB; fwd_a2 = 0 -> fwd_hit2 = 0.
REQ-043 SHALL test: full queue with simultaneous pop and push attempt -> push rejected, count = 3.
REQ-044 SHALL test: reset pulse with 3 entries pending -> count = 0, grf_we = 0 immediately, no further writes.
